// File: rtl/stuff_serializer_if.sv
// Byte-in / bit-out bundle for the stuffing serializer.
// The master side offers bytes; the slave side (the serializer) drives the serial stream.
interface stuff_serializer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       w;
  logic       w_valid;
  logic       frame_done;
  logic [1:0] stuff_cnt;

  modport master (
    output in_valid, in_data,
    input  in_ready, w, w_valid, frame_done, stuff_cnt
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, w, w_valid, frame_done, stuff_cnt
  );
endinterface

// File: rtl/stuff_serializer.sv
// Serializes one byte MSB first and inserts a complement bit after every run of three
// equal bits, so the stream never carries four equal consecutive bits within a frame.
module stuff_serializer (
  input  logic              clk,
  input  logic              reset,
  stuff_serializer_if.slave bus
);

  // state_q describes what w carries in the current cycle
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STUFF = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [2:0] remain_q, remain_d;
  logic       run_val_q, run_val_d;
  logic [1:0] run_len_q, run_len_d;
  logic [1:0] scnt_q, scnt_d;
  logic       w_q, w_d;
  logic       w_valid_q, w_valid_d;
  logic       done_q, done_d;
  logic [1:0] stuff_cnt_q, stuff_cnt_d;

  logic       handshake;
  logic       next_bit;
  logic [1:0] data_len;

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.w          = w_q;
  assign bus.w_valid    = w_valid_q;
  assign bus.frame_done = done_q;
  assign bus.stuff_cnt  = stuff_cnt_q;

  assign handshake = bus.in_valid && (state_q == IDLE);
  assign next_bit  = shift_q[6];
  // Run length the next data bit would produce; only used when the run is below three.
  assign data_len  = (next_bit == run_val_q) ? (run_len_q + 2'd1) : 2'd1;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    remain_d    = remain_q;
    run_val_d   = run_val_q;
    run_len_d   = run_len_q;
    scnt_d      = scnt_q;
    w_d         = 1'b0;
    w_valid_d   = 1'b0;
    done_d      = 1'b0;
    stuff_cnt_d = stuff_cnt_q;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          w_d       = bus.in_data[7];
          w_valid_d = 1'b1;
          shift_d   = bus.in_data[6:0];
          remain_d  = 3'd7;
          run_val_d = bus.in_data[7];
          run_len_d = 2'd1;
          scnt_d    = 2'd0;
          state_d   = DATA;
        end
      end
      DATA, STUFF: begin
        if (run_len_q == 2'd3) begin
          w_d       = ~run_val_q;
          w_valid_d = 1'b1;
          run_val_d = ~run_val_q;
          run_len_d = 2'd1;
          scnt_d    = scnt_q + 2'd1;
          state_d   = STUFF;
          if (remain_q == 3'd0) begin
            done_d      = 1'b1;
            stuff_cnt_d = scnt_q + 2'd1;
          end
        end else if (remain_q != 3'd0) begin
          w_d       = next_bit;
          w_valid_d = 1'b1;
          shift_d   = {shift_q[5:0], 1'b0};
          remain_d  = remain_q - 3'd1;
          run_val_d = next_bit;
          run_len_d = data_len;
          state_d   = DATA;
          // The last data bit ends the frame unless it completes a run and owes a stuff bit.
          if (remain_q == 3'd1 && data_len != 2'd3) begin
            done_d      = 1'b1;
            stuff_cnt_d = scnt_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= 7'd0;
      remain_q    <= 3'd0;
      run_val_q   <= 1'b0;
      run_len_q   <= 2'd0;
      scnt_q      <= 2'd0;
      w_q         <= 1'b0;
      w_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      stuff_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      remain_q    <= remain_d;
      run_val_q   <= run_val_d;
      run_len_q   <= run_len_d;
      scnt_q      <= scnt_d;
      w_q         <= w_d;
      w_valid_q   <= w_valid_d;
      done_q      <= done_d;
      stuff_cnt_q <= stuff_cnt_d;
    end
  end

endmodule

// File: tb/tb_stuff_serializer.sv
// Scoreboard bench: the driver queues each accepted byte, a negedge monitor rebuilds
// frames from w and checks them against a bit-list reference model and a de-stuffer.
module tb_stuff_serializer;

  logic clk = 1'b0;
  logic reset;

  stuff_serializer_if bus ();

  stuff_serializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_sent = 0;
  int frames_aborted = 0;
  int frames_seen = 0;
  bit mon_en = 1'b0;

  logic [7:0] exp_data_q[$];
  int         exp_start_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endfunction

  // Reference: emit data bits MSB first; whenever the last three emitted bits are
  // equal, append their complement.
  function automatic void model(input logic [7:0] d, output logic [0:10] bits,
                                output int len, output int nst);
    bits = '0;
    len  = 0;
    nst  = 0;
    for (int i = 7; i >= 0; i--) begin
      bits[len] = d[i];
      len++;
      if (len >= 3 && bits[len-1] == bits[len-2] && bits[len-2] == bits[len-3]) begin
        bits[len] = ~bits[len-1];
        len++;
        nst++;
      end
    end
  endfunction

  // Receiver view: drop the bit following any run of three equal bits.
  function automatic logic [7:0] destuff(input logic [0:10] rx, input int n);
    logic [7:0] out;
    logic       prev;
    int         run;
    bit         skip;
    out  = 8'd0;
    prev = 1'b0;
    run  = 0;
    skip = 1'b0;
    for (int i = 0; i < n && i < 11; i++) begin
      if (skip) begin
        skip = 1'b0;
        prev = rx[i];
        run  = 1;
        continue;
      end
      out  = {out[6:0], rx[i]};
      run  = (run > 0 && rx[i] == prev) ? run + 1 : 1;
      prev = rx[i];
      if (run == 3) skip = 1'b1;
    end
    return out;
  endfunction

  // ---------------- monitor ----------------
  logic [0:10] rx_bits;
  int          rx_n = 0;
  int          first_cyc = 0;
  logic [1:0]  exp_stuff = 2'd0;
  bit          abort_seen = 1'b0;

  task automatic check_frame();
    logic [7:0]  d;
    int          start;
    logic [0:10] eb;
    int          elen;
    int          enst;
    frames_seen++;
    if (exp_data_q.size() == 0) begin
      check(1'b0, $sformatf("unexpected_frame got %0d bits, required no frame", rx_n));
    end else begin
      d     = exp_data_q.pop_front();
      start = exp_start_q.pop_front();
      model(d, eb, elen, enst);
      check(rx_n == elen && (rx_bits >> (11 - elen)) == (eb >> (11 - elen)),
            $sformatf("frame_bits byte=%h got %0d bits %b required %0d bits %b",
                      d, rx_n, rx_bits, elen, eb));
      check(bus.stuff_cnt == 2'(enst),
            $sformatf("stuff_cnt byte=%h got %0d required %0d", d, bus.stuff_cnt, enst));
      check(destuff(rx_bits, rx_n) == d,
            $sformatf("destuff got %h required %h", destuff(rx_bits, rx_n), d));
      check(first_cyc == start,
            $sformatf("latency byte=%h first bit cycle %0d required %0d", d, first_cyc, start));
      $display("frame byte=%h bits=%0d stuff=%0d", d, rx_n, bus.stuff_cnt);
      exp_stuff = 2'(enst);
    end
    rx_n = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check(bus.in_ready === !bus.w_valid,
            $sformatf("in_ready got %b required %b", bus.in_ready, !bus.w_valid));
      if (bus.w_valid === 1'b1) begin
        if (rx_n == 0) first_cyc = cyc;
        if (rx_n >= 3 && rx_n <= 11)
          check(!(rx_bits[rx_n-1] == bus.w && rx_bits[rx_n-2] == bus.w &&
                  rx_bits[rx_n-3] == bus.w),
                $sformatf("run4 detector fired at bit %0d value %b", rx_n, bus.w));
        if (rx_n < 11) rx_bits[rx_n] = bus.w;
        rx_n++;
        if (rx_n > 11) check(1'b0, $sformatf("frame_len got %0d bits required <= 11", rx_n));
        if (bus.frame_done === 1'b1) check_frame();
        else check(bus.stuff_cnt === exp_stuff,
                   $sformatf("stuff_hold got %0d required %0d", bus.stuff_cnt, exp_stuff));
      end else begin
        check(bus.w === 1'b0 && bus.frame_done === 1'b0 && bus.stuff_cnt === exp_stuff,
              $sformatf("idle w=%b done=%b stuff=%0d required 0 0 %0d",
                        bus.w, bus.frame_done, bus.stuff_cnt, exp_stuff));
        if (rx_n != 0)
          check(abort_seen, $sformatf("frame_trunc got %0d bits without frame_done", rx_n));
        rx_n = 0;
        abort_seen = 1'b0;
      end
      if (reset) begin
        exp_data_q.delete();
        exp_start_q.delete();
        exp_stuff  = 2'd0;
        abort_seen = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [7:0] d);
    int budget;
    budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && budget < 40) begin
      @(posedge clk); #1;
      budget++;
    end
    check(bus.in_ready === 1'b1, $sformatf("send_wait byte=%h in_ready=%b required 1",
                                           d, bus.in_ready));
    if (bus.in_ready === 1'b1) begin
      exp_data_q.push_back(d);
      exp_start_q.push_back(cyc + 1);
      frames_sent++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check(bus.w === 1'b0 && bus.w_valid === 1'b0 && bus.frame_done === 1'b0 &&
          bus.stuff_cnt === 2'd0 && bus.in_ready === 1'b1,
          $sformatf("%s w=%b w_valid=%b done=%b stuff=%0d ready=%b required 0 0 0 0 1",
                    tag, bus.w, bus.w_valid, bus.frame_done, bus.stuff_cnt, bus.in_ready));
  endtask

  initial begin
    int budget;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset_state");
    mon_en = 1'b1;

    send(8'hAA); idle(2);
    send(8'hFF); idle(2);
    send(8'h00); idle(1);
    send(8'hE6); idle(1);
    send(8'hE3); idle(1);
    // in_valid held high across the frame: 0x55 must wait for in_ready
    send(8'h0F); send(8'h55); idle(3);
    send(8'hE6); idle(2);

    // abort a 0xFF frame in its fifth bit cycle, with in_valid still offered
    send(8'hFF);
    repeat (4) begin
      @(posedge clk); #1;
    end
    bus.in_data = 8'h3C;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    frames_aborted++;
    check_reset_state("abort_state");
    send(8'hAA); idle(2);

    for (int i = 0; i < 40; i++) begin
      send(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(1);
    budget = 0;
    while ((exp_data_q.size() != 0 || bus.w_valid !== 1'b0) && budget < 60) begin
      @(posedge clk); #1;
      budget++;
    end
    check(budget < 60, $sformatf("drain_timeout pending=%0d required 0", exp_data_q.size()));
    idle(2);
    check(frames_seen == frames_sent - frames_aborted,
          $sformatf("frame_count got %0d required %0d", frames_seen,
                    frames_sent - frames_aborted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stuff_serializer.md
STUFF_SERIALIZER -- requirements
Module: stuff_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 in_valid  input  1  upstream offers a byte on in_data.
REQ-005 in_data  input  8  parallel byte; captured only on handshake.
REQ-006 in_ready  output  1  block can accept a byte; high exactly when no frame is in progress.
REQ-007 w  output  1  serial bit stream to the downstream run detector, registered.
REQ-008 w_valid  output  1  w carries a frame bit this cycle, registered.
REQ-009 frame_done  output  1  one-cycle pulse coincident with the last w_valid cycle of a frame.
REQ-010 stuff_cnt  output  2  number of stuff bits inserted in the most recently completed frame.

Function
REQ-011 A handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is captured on that edge.
REQ-012 in_valid while in_ready=0 SHALL be ignored; in_data is not sampled, and no queuing occurs.
REQ-013 States: IDLE (in_ready=1, w_valid=0), DATA (emitting data bit), STUFF (emitting stuff bit); IDLE->DATA on handshake.
REQ-014 The first frame bit (in_data[7]) SHALL appear on w with w_valid=1 in the cycle after the handshake edge (latency 1).
REQ-015 Data bits SHALL be emitted MSB first, one per cycle, in contiguous w_valid=1 cycles.
REQ-016 Run tracking: run value and run length (1..3) SHALL cover every emitted bit, data or stuff, and clear at each handshake.
REQ-017 When an emitted bit makes the run length 3, the next cycle SHALL emit a stuff bit equal to the complement of the run value (DATA->STUFF).
REQ-018 A stuff bit SHALL start a new run of length 1 with its own value; STUFF->DATA if data bits remain, else end of frame.
REQ-019 A stuff bit due after data bit 0 SHALL still be emitted as the final frame bit.
REQ-020 A frame SHALL be 8 data bits plus 0..3 stuff bits (8..11 cycles); no output sequence within a frame may contain 4 equal consecutive bits.
REQ-021 frame_done SHALL be 1 only in the last w_valid=1 cycle of a frame; stuff_cnt SHALL update with that frame's count in the same cycle and hold until the next frame_done.
REQ-022 In the cycle after the last frame bit, w_valid=0 and w=0 and in_ready=1; the earliest next handshake is on the edge ending that cycle, so at least one w_valid=0 cycle lies between frames.
REQ-023 While w_valid=0, w SHALL be 0; run-free guarantee is not required across inter-frame gaps.

Reset
REQ-024 On a rising edge with reset=1 the block SHALL enter IDLE: w=0, w_valid=0, frame_done=0, stuff_cnt=0, in_ready=1 from the next cycle.
REQ-025 Reset mid-frame SHALL abort the frame: no further w_valid=1 and no frame_done for that frame; reset has priority over a simultaneous handshake.

Verification
REQ-026 Accept 0xAA -> w = 1,0,1,0,1,0,1,0 over 8 cycles, frame_done on the 8th, stuff_cnt=0.
REQ-027 Accept 0xFF -> w = 1,1,1,0,1,1,1,0,1,1 (10 cycles), stuff_cnt=2; accept 0x00 -> 0,0,0,1,0,0,0,1,0,0, stuff_cnt=2.
REQ-028 Accept 0xE6 -> w = 1,1,1,0,0,0,1,1,1,0,0 (11 cycles, maximum), stuff_cnt=3; accept 0xE3 -> 1,1,1,0,0,0,1,0,1,1, stuff_cnt=2.
REQ-029 Hold in_valid=1 with 0x0F then 0x55 -> 0x0F frame (0,0,0,1,0,1,1,1,0,1 with stuffs at positions 4 and 9), one gap cycle with w_valid=0, then 0x55 frame; 0x55 accepted only when in_ready=1.
REQ-030 Assert reset during cycle 5 of a 0xFF frame -> w_valid=0 next cycle, no frame_done, stuff_cnt=0, in_ready=1; next byte 0xAA serialises normally.
REQ-031 Random bytes back to back -> scoreboard de-stuffs w and matches in_data, and a downstream 4-equal-bit detector on w never fires during w_valid=1 cycles.
